// File: rtl/scroll_fetch_seq_pkg.sv
// Shared definitions for the scroll-RAM fetch sequencer: FSM encoding, RAM base
// addresses, GFX slot phase constants and address-forming helpers.
package scroll_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_HA_LO = 3'd1,
      ST_HA_HI = 3'd2,
      ST_HB_LO = 3'd3,
      ST_HB_HI = 3'd4,
      ST_HDONE = 3'd5,
      ST_VCOL  = 3'd6
   } state_t;

   localparam logic [10:0] HS_A_BASE = 11'h400;
   localparam logic [10:0] HS_B_BASE = 11'h600;
   localparam logic [10:0] VS_A_BASE = 11'h000;
   localparam logic [10:0] VS_B_BASE = 11'h080;

   // A GFX slot is two pixels; each pixel is six MCLK phases.
   localparam logic       LAUNCH_PIX  = 1'b0;
   localparam logic [2:0] LAUNCH_PH   = 3'd5;
   localparam logic       CAPTURE_PIX = 1'b1;
   localparam logic [2:0] CAPTURE_PH  = 3'd3;
   localparam logic       UPDATE_PIX  = 1'b1;
   localparam logic [2:0] UPDATE_PH   = 3'd4;

   function automatic logic [10:0] hs_addr(input logic [10:0] base,
                                           input logic [7:0]  vcnt,
                                           input logic        hi);
      return base + {2'b00, vcnt, hi};
   endfunction

   function automatic logic [10:0] vs_addr(input logic       h4,
                                           input logic [5:0] col);
      return (h4 ? VS_B_BASE : VS_A_BASE) + {5'b00000, col};
   endfunction

endpackage

// File: rtl/scroll_fetch_seq_slot_timer.sv
// Decodes the emulator timing bus into the per-slot launch, capture and
// address-update strobes.
module scroll_slot_timer
   import scroll_pkg::*;
(
   input  logic [4:0] i_EMU_TIMING,
   output logic       o_launch,
   output logic       o_capture,
   output logic       o_addr_update
);

   logic [2:0] w_phase;
   logic       w_parity;
   logic       w_unused_timing;

   assign w_phase         = i_EMU_TIMING[2:0];
   assign w_parity        = i_EMU_TIMING[3];
   assign w_unused_timing = i_EMU_TIMING[4];

   assign o_launch      = (w_parity == LAUNCH_PIX)  && (w_phase == LAUNCH_PH);
   assign o_capture     = (w_parity == CAPTURE_PIX) && (w_phase == CAPTURE_PH);
   assign o_addr_update = (w_parity == UPDATE_PIX)  && (w_phase == UPDATE_PH);

endmodule

// File: rtl/scroll_fetch_seq.sv
// Scroll-RAM fetch sequencer: reads per-line HSCROLL in horizontal blank and
// per-column VSCROLL during the active line for two tilemap layers.
module scroll_fetch_seq
   import scroll_pkg::*;
(
   input  logic        i_EMU_MCLK,
   input  logic        i_EMU_RST_n,
   input  logic [4:0]  i_EMU_TIMING,
   input  logic        i_VCLK,
   input  logic        i_H4,
   input  logic [8:0]  i_HCNT,
   input  logic [7:0]  i_VCNT,
   output logic [10:0] o_GFXADDR,
   input  logic [7:0]  i_GFXDATA,
   output logic [8:0]  o_TMA_HSCROLL,
   output logic [8:0]  o_TMB_HSCROLL,
   output logic [7:0]  o_TMA_VSCROLL,
   output logic [7:0]  o_TMB_VSCROLL,
   output logic        o_FETCH_ERR
);

   logic w_launch;
   logic w_capture;
   logic w_addr_upd;

   scroll_slot_timer u_slot_timer (
      .i_EMU_TIMING  (i_EMU_TIMING),
      .o_launch      (w_launch),
      .o_capture     (w_capture),
      .o_addr_update (w_addr_upd)
   );

   state_t      r_state;
   logic        r_vclk_d;
   logic [2:0]  r_hcnt_lo_d;
   logic        r_addr_vld;
   logic        r_launched;
   logic        r_vsel;
   logic [10:0] r_gfxaddr;
   logic [8:0]  r_sh_a, r_sh_b;
   logic [8:0]  r_tma_h, r_tmb_h;
   logic [7:0]  r_stg_a, r_stg_b;
   logic [7:0]  r_tma_v, r_tmb_v;
   logic        r_err;

   logic       w_vclk_fall;
   logic       w_vclk_rise;
   logic       w_col_roll;
   logic       w_cap_ok;
   logic [5:0] w_col_next;

   assign w_vclk_fall = r_vclk_d & ~i_VCLK;
   assign w_vclk_rise = ~r_vclk_d & i_VCLK;
   assign w_col_roll  = (r_hcnt_lo_d == 3'd7) && (i_HCNT[2:0] == 3'd0);
   assign w_col_next  = i_HCNT[8:3] + 6'd1;
   // Only capture data whose address was both set and launched in this state.
   assign w_cap_ok    = w_capture & r_launched;

   always_ff @(posedge i_EMU_MCLK or negedge i_EMU_RST_n) begin
      if (!i_EMU_RST_n) begin
         r_state     <= ST_IDLE;
         r_vclk_d    <= 1'b0;
         r_hcnt_lo_d <= 3'd0;
         r_addr_vld  <= 1'b0;
         r_launched  <= 1'b0;
         r_vsel      <= 1'b0;
         r_gfxaddr   <= 11'd0;
         r_sh_a      <= 9'd0;
         r_sh_b      <= 9'd0;
         r_tma_h     <= 9'd0;
         r_tmb_h     <= 9'd0;
         r_stg_a     <= 8'd0;
         r_stg_b     <= 8'd0;
         r_tma_v     <= 8'd0;
         r_tmb_v     <= 8'd0;
         r_err       <= 1'b0;
      end else begin
         r_vclk_d    <= i_VCLK;
         r_hcnt_lo_d <= i_HCNT[2:0];
         if (w_col_roll) begin
            r_tma_v <= r_stg_a;
            r_tmb_v <= r_stg_b;
         end
         // VCLK edges outrank any slot event landing on the same clock.
         if (w_vclk_rise) begin
            r_state    <= ST_IDLE;
            r_addr_vld <= 1'b0;
            r_launched <= 1'b0;
         end else if (w_vclk_fall) begin
            r_state    <= ST_VCOL;
            r_addr_vld <= 1'b0;
            r_launched <= 1'b0;
            if (r_state == ST_HDONE) begin
               r_tma_h <= r_sh_a;
               r_tmb_h <= r_sh_b;
            end else begin
               r_err <= 1'b1;
            end
         end else begin
            if (w_launch) begin
               r_launched <= r_addr_vld;
            end
            if (w_cap_ok) begin
               case (r_state)
                  ST_HA_LO: r_sh_a[7:0] <= i_GFXDATA;
                  ST_HA_HI: r_sh_a[8]   <= i_GFXDATA[0];
                  ST_HB_LO: r_sh_b[7:0] <= i_GFXDATA;
                  ST_HB_HI: r_sh_b[8]   <= i_GFXDATA[0];
                  ST_VCOL: begin
                     if (r_vsel) r_stg_b <= i_GFXDATA;
                     else        r_stg_a <= i_GFXDATA;
                  end
                  default: ;
               endcase
            end
            if (w_addr_upd) begin
               r_launched <= 1'b0;
               case (r_state)
                  ST_IDLE: begin
                     if (i_VCLK) begin
                        r_state    <= ST_HA_LO;
                        r_gfxaddr  <= hs_addr(HS_A_BASE, i_VCNT, 1'b0);
                        r_addr_vld <= 1'b1;
                     end
                  end
                  ST_HA_LO: begin
                     r_state   <= ST_HA_HI;
                     r_gfxaddr <= hs_addr(HS_A_BASE, i_VCNT, 1'b1);
                  end
                  ST_HA_HI: begin
                     r_state   <= ST_HB_LO;
                     r_gfxaddr <= hs_addr(HS_B_BASE, i_VCNT, 1'b0);
                  end
                  ST_HB_LO: begin
                     r_state   <= ST_HB_HI;
                     r_gfxaddr <= hs_addr(HS_B_BASE, i_VCNT, 1'b1);
                  end
                  ST_HB_HI: begin
                     r_state    <= ST_HDONE;
                     r_addr_vld <= 1'b0;
                  end
                  ST_VCOL: begin
                     r_gfxaddr  <= vs_addr(i_H4, w_col_next);
                     r_vsel     <= i_H4;
                     r_addr_vld <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   assign o_GFXADDR     = r_gfxaddr;
   assign o_TMA_HSCROLL = r_tma_h;
   assign o_TMB_HSCROLL = r_tmb_h;
   assign o_TMA_VSCROLL = r_tma_v;
   assign o_TMB_VSCROLL = r_tmb_v;
   assign o_FETCH_ERR   = r_err;

endmodule

// File: tb/tb_scroll_fetch_seq.sv
// Randomized self-checking bench for scroll_fetch_seq with a behavioural scroll-RAM
// model; expectations are derived from line/column/slot arithmetic.
module tb_scroll_fetch_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  timing;
   logic        vclk;
   logic        h4;
   logic [8:0]  hcnt;
   logic [7:0]  vcnt;
   logic [10:0] gfxaddr;
   logic [7:0]  gfxdata;
   logic [8:0]  tma_h, tmb_h;
   logic [7:0]  tma_v, tmb_v;
   logic        ferr;

   logic [7:0]  ram [2048];
   int          pix, ph, h4_force;
   int          errors, checks;
   logic [8:0]  exp_a, exp_b;

   always #5 clk = ~clk;
   assign gfxdata = ram[gfxaddr];

   scroll_fetch_seq dut (
      .i_EMU_MCLK    (clk),
      .i_EMU_RST_n   (rst_n),
      .i_EMU_TIMING  (timing),
      .i_VCLK        (vclk),
      .i_H4          (h4),
      .i_HCNT        (hcnt),
      .i_VCNT        (vcnt),
      .o_GFXADDR     (gfxaddr),
      .i_GFXDATA     (gfxdata),
      .o_TMA_HSCROLL (tma_h),
      .o_TMB_HSCROLL (tmb_h),
      .o_TMA_VSCROLL (tma_v),
      .o_TMB_VSCROLL (tmb_v),
      .o_FETCH_ERR   (ferr)
   );

   // Reference: line HSCROLL for a layer is {bit0 of odd byte, even byte} at base+2*line.
   function automatic logic [8:0] exp_hs(input int base, input int v);
      return 9'((ram[base + 2*v + 1] & 8'h01) * 256 + ram[base + 2*v]);
   endfunction

   // Reference: address launched in the slot starting at pixel p was chosen on pixel p-1,
   // pointing at the next 8-px column of the layer picked by 4H.
   function automatic logic [10:0] exp_vaddr(input int p);
      int q, col, layer_b;
      q = (p - 1) % 512;
      col = (q / 8 + 1) % 64;
      layer_b = (h4_force < 0) ? ((q / 4) % 2) : h4_force;
      return 11'(layer_b * 128 + col);
   endfunction

   task automatic drive();
      logic [8:0] p9;
      p9 = pix[8:0];
      timing = {1'b0, p9[0], 3'(ph)};
      hcnt = p9;
      h4 = (h4_force < 0) ? p9[2] : h4_force[0];
   endtask

   task automatic step();
      ph = ph + 1;
      if (ph == 6) begin
         ph = 0;
         pix = pix + 1;
      end
      drive();
      @(posedge clk);
      #1;
   endtask

   task automatic align();
      while (!(pix[0] == 1'b1 && ph == 5)) step();
   endtask

   task automatic run_slots(input logic v, input int n);
      vclk = v;
      repeat (12 * n) step();
   endtask

   task automatic advance_to(input int target);
      while (!(ph == 5 && ((pix + 1) % 512) == target)) step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; vclk = 1'b0; vcnt = 8'd0; h4_force = -1; pix = 0; ph = 0;
      drive();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (gfxaddr !== 11'h000) begin errors++; $display("FAIL reset_addr: got %h want 000", gfxaddr); end
      checks++; if ({tma_h, tmb_h} !== 18'h0) begin errors++; $display("FAIL reset_hscroll: got %h/%h want 0/0", tma_h, tmb_h); end
      checks++; if ({tma_v, tmb_v} !== 16'h0) begin errors++; $display("FAIL reset_vscroll: got %h/%h want 0/0", tma_v, tmb_v); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", ferr); end
      rst_n = 1'b1;
      exp_a = 9'h0; exp_b = 9'h0;
   endtask

   task automatic test_hscroll();
      int s;
      ram[11'h446] = 8'h34; ram[11'h447] = 8'h01; ram[11'h646] = 8'hFF; ram[11'h647] = 8'hFE;
      vcnt = 8'h23;
      align();
      vclk = 1'b1;
      for (int k = 0; k < 72; k++) begin
         step();
         if (ph == 5 && pix[0] == 1'b0 && k >= 12 && k < 60) begin
            s = k / 12;
            checks++;
            if (gfxaddr !== 11'(((s <= 2) ? 11'h446 : 11'h646) + (s - 1) % 2)) begin
               errors++; $display("FAIL hs_fixed_addr slot%0d: got %h", s, gfxaddr);
            end
         end
      end
      checks++; if (tma_h !== 9'h000) begin errors++; $display("FAIL hs_shadow_only: got %h want 000", tma_h); end
      vclk = 1'b0;
      step();
      exp_a = 9'h134; exp_b = 9'h0FF;
      checks++; if (tma_h !== exp_a) begin errors++; $display("FAIL hs_fixed_a: got %h want %h", tma_h, exp_a); end
      checks++; if (tmb_h !== exp_b) begin errors++; $display("FAIL hs_fixed_b: got %h want %h", tmb_h, exp_b); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL hs_fixed_err: got %b want 0", ferr); end
      repeat (11) step();
      run_slots(1'b0, 3);
   endtask

   task automatic test_hscroll_random();
      int v, nh, nl, s;
      logic [10:0] la;
      la = 11'h0;
      for (int line = 0; line < 5; line++) begin
         v = $urandom_range(0, 255); nh = $urandom_range(5, 8); nl = $urandom_range(2, 4);
         vcnt = 8'(v);
         align();
         vclk = 1'b1;
         for (int k = 0; k < 12 * nh; k++) begin
            step();
            if (ph == 5 && pix[0] == 1'b0) begin
               la = gfxaddr;
               if (k >= 12 && k < 60) begin
                  s = k / 12;
                  checks++;
                  if (gfxaddr !== 11'(((s <= 2) ? 1024 : 1536) + 2 * v + (s - 1) % 2)) begin
                     errors++; $display("FAIL hs_rand_addr line%0d slot%0d: got %h", line, s, gfxaddr);
                  end
               end
            end
            if (ph == 3 && pix[0] == 1'b1) begin
               checks++;
               if (gfxaddr !== la) begin errors++; $display("FAIL addr_stable_blank: got %h want %h", gfxaddr, la); end
            end
         end
         checks++; if (tma_h !== exp_a) begin errors++; $display("FAIL hs_rand_hold: got %h want %h", tma_h, exp_a); end
         exp_a = exp_hs(1024, v); exp_b = exp_hs(1536, v);
         vclk = 1'b0;
         step();
         checks++; if (tma_h !== exp_a) begin errors++; $display("FAIL hs_rand_a: got %h want %h", tma_h, exp_a); end
         checks++; if (tmb_h !== exp_b) begin errors++; $display("FAIL hs_rand_b: got %h want %h", tmb_h, exp_b); end
         checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL hs_rand_err: got %b want 0", ferr); end
         repeat (11) step();
         run_slots(1'b0, nl);
      end
   endtask

   task automatic test_fetch_err();
      int p, v;
      vcnt = 8'($urandom);
      align();
      run_slots(1'b1, 3);
      vclk = 1'b0;
      step();
      p = pix;
      checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", ferr); end
      checks++; if ({tma_h, tmb_h} !== {exp_a, exp_b}) begin errors++; $display("FAIL err_hold: got %h/%h want %h/%h", tma_h, tmb_h, exp_a, exp_b); end
      while (!(pix == p + 2 && ph == 5)) step();
      checks++; if (gfxaddr !== exp_vaddr(pix)) begin errors++; $display("FAIL err_vcol_addr: got %h want %h", gfxaddr, exp_vaddr(pix)); end
      align();
      run_slots(1'b0, 1);
      v = $urandom_range(0, 255);
      vcnt = 8'(v);
      run_slots(1'b1, 6);
      exp_a = exp_hs(1024, v); exp_b = exp_hs(1536, v);
      vclk = 1'b0;
      step();
      checks++; if ({tma_h, tmb_h} !== {exp_a, exp_b}) begin errors++; $display("FAIL err_next_line: got %h/%h want %h/%h", tma_h, tmb_h, exp_a, exp_b); end
      checks++; if (ferr !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", ferr); end
      repeat (11) step();
      run_slots(1'b0, 2);
   endtask

   task automatic test_vscroll_wrap();
      ram[11'h000] = 8'h5A; ram[11'h040] = 8'hA5; ram[11'h0C0] = 8'hC3;
      ram[11'h080] = 8'($urandom);
      vclk = 1'b1;
      advance_to(9'h1F0);
      vclk = 1'b0;
      while (!(pix[8:0] == 9'h1FA && ph == 5)) step();
      checks++; if (gfxaddr !== 11'h000) begin errors++; $display("FAIL wrap_addr_a: got %h want 000", gfxaddr); end
      while (!(pix[8:0] == 9'h1FE && ph == 5)) step();
      checks++; if (gfxaddr !== 11'h080) begin errors++; $display("FAIL wrap_addr_b: got %h want 080", gfxaddr); end
      while (!(pix[8:0] == 9'h000 && ph == 3)) step();
      checks++; if (tma_v !== 8'h5A) begin errors++; $display("FAIL wrap_vs_a: got %h want 5a", tma_v); end
      checks++; if (tmb_v !== ram[11'h080]) begin errors++; $display("FAIL wrap_vs_b: got %h want %h", tmb_v, ram[11'h080]); end
   endtask

   task automatic test_vscroll_b();
      ram[11'h086] = 8'h77;
      ram[11'h006] = ~ram[11'h005];
      advance_to(9'h028);
      h4_force = 1;
      while (!(pix[8:0] == 9'h02E && ph == 5)) step();
      checks++; if (gfxaddr !== 11'h086) begin errors++; $display("FAIL vsb_addr: got %h want 086", gfxaddr); end
      while (!(pix[8:0] == 9'h030 && ph == 3)) step();
      checks++; if (tmb_v !== 8'h77) begin errors++; $display("FAIL vsb_b: got %h want 77", tmb_v); end
      checks++; if (tma_v !== ram[11'h005]) begin errors++; $display("FAIL vsb_a_hold: got %h want %h", tma_v, ram[11'h005]); end
      h4_force = -1;
   endtask

   task automatic test_vscroll_random();
      logic [10:0] la;
      int col;
      la = 11'h0;
      for (int i = 0; i < 256; i++) ram[i] = 8'($urandom);
      for (int k = 0; k < 20 * 48; k++) begin
         step();
         if (ph == 5 && pix[0] == 1'b0) begin
            la = gfxaddr;
            if (k > 48) begin
               checks++;
               if (gfxaddr !== exp_vaddr(pix)) begin errors++; $display("FAIL vs_rand_addr px%0d: got %h want %h", pix % 512, gfxaddr, exp_vaddr(pix)); end
            end
         end
         if (ph == 3 && pix[0] == 1'b1 && k > 48) begin
            checks++;
            if (gfxaddr !== la) begin errors++; $display("FAIL addr_stable_active: got %h want %h", gfxaddr, la); end
         end
         if (ph == 3 && (pix % 8) == 0 && k >= 96) begin
            col = (pix % 512) / 8;
            checks++;
            if ({tma_v, tmb_v} !== {ram[col], ram[128 + col]}) begin
               errors++; $display("FAIL vs_rand col%0d: got %h/%h want %h/%h", col, tma_v, tmb_v, ram[col], ram[128 + col]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      int v;
      v = $urandom_range(0, 255);
      vcnt = 8'(v);
      align();
      vclk = 1'b1;
      repeat (40) step();
      checks++; if (gfxaddr !== 11'(1536 + 2 * v)) begin errors++; $display("FAIL rm_hb_lo_addr: got %h want %h", gfxaddr, 11'(1536 + 2 * v)); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (gfxaddr !== 11'h000) begin errors++; $display("FAIL rm_addr: got %h want 000", gfxaddr); end
      checks++; if ({tma_h, tmb_h, tma_v, tmb_v} !== 34'h0) begin errors++; $display("FAIL rm_scroll: got %h/%h/%h/%h want 0", tma_h, tmb_h, tma_v, tmb_v); end
      checks++; if (ferr !== 1'b0) begin errors++; $display("FAIL rm_err: got %b want 0", ferr); end
      vclk = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 60; k++) begin
         step();
         if (ph == 5 && pix[0] == 1'b0) begin
            checks++;
            if (gfxaddr !== 11'h000) begin errors++; $display("FAIL rm_no_fetch: got %h want 000", gfxaddr); end
         end
      end
      align();
      vclk = 1'b1;
      for (int k = 0; k < 24; k++) begin
         step();
         if (k == 17) begin
            checks++;
            if (gfxaddr !== 11'(1024 + 2 * v)) begin errors++; $display("FAIL rm_restart: got %h want %h", gfxaddr, 11'(1024 + 2 * v)); end
         end
      end
   endtask

   initial begin
      errors = 0; checks = 0; h4_force = -1; pix = 0; ph = 0;
      for (int i = 0; i < 2048; i++) ram[i] = 8'($urandom);
      test_reset();
      test_hscroll();
      test_hscroll_random();
      test_fetch_err();
      test_vscroll_wrap();
      test_vscroll_b();
      test_vscroll_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/scroll_fetch_seq.md
SCROLL_FETCH_SEQ -- requirements
Module: scroll_fetch_seq

Interface
REQ-001 SHALL have port i_EMU_MCLK input 1: 36.864 MHz master clock; the only clock.
REQ-002 SHALL have port i_EMU_RST_n input 1: asynchronous active-low reset.
REQ-003 SHALL have port i_EMU_TIMING input 5: [2:0] MCLK phase 0..5 within a pixel; [3] pixel parity (0 = pixel 0 of a 2-pixel GFX slot).
REQ-004 SHALL have port i_VCLK input 1: 1 = horizontal-blank HSCROLL window; 0 = active VSCROLL window.
REQ-005 SHALL have port i_H4 input 1: 4H bit; 0 selects TM-A and 1 selects TM-B for VSCROLL fetch.
REQ-006 SHALL have port i_HCNT input 9: horizontal pixel counter; [8:3] is the 8-px column index.
REQ-007 SHALL have port i_VCNT input 8: scanline of the next line to display.
REQ-008 SHALL have port o_GFXADDR output 11: scroll-RAM GFX-side address.
REQ-009 SHALL have port i_GFXDATA input 8: scroll-RAM GFX-side read data.
REQ-010 SHALL have ports o_TMA_HSCROLL and o_TMB_HSCROLL output 9: active-line horizontal scroll per layer.
REQ-011 SHALL have ports o_TMA_VSCROLL and o_TMB_VSCROLL output 8: current-column vertical scroll per layer.
REQ-012 SHALL have port o_FETCH_ERR output 1: sticky flag, set when the HSCROLL sequence is incomplete at the VCLK fall.

Function
REQ-013 SHALL define a GFX slot as two pixels; launch at pixel 0 phase 5 (address must be stable); capture at pixel 1 phase 3.
REQ-014 SHALL change o_GFXADDR only at the pixel 1 phase 4 edge, so the address stays constant from launch through capture.
REQ-015 SHALL run FSM states IDLE, HA_LO, HA_HI, HB_LO, HB_HI, HDONE, VCOL.
REQ-016 SHALL leave IDLE for HA_LO on the first slot boundary (pixel 1 phase 4) with i_VCLK=1.
REQ-017 SHALL advance HA_LO→HA_HI→HB_LO→HB_HI→HDONE one state per slot, with one capture each.
REQ-018 SHALL use HSCROLL addresses TM-A 0x400+{VCNT,lo/hi} and TM-B 0x600+{VCNT,lo/hi}, with lo at even and hi at odd addresses.
REQ-019 SHALL form the 9-bit HSCROLL as {hi[0], lo[7:0]}; hi[7:1] SHALL be ignored.
REQ-020 SHALL capture HSCROLL into shadow registers only; the shadows SHALL transfer to o_TMx_HSCROLL on the clock after the i_VCLK 1→0 edge.
REQ-021 SHALL, on i_VCLK 1→0 from any state, enter VCOL.
REQ-022 SHALL, if that 1→0 edge occurs before HDONE, skip the transfer (outputs hold), set o_FETCH_ERR, and still enter VCOL.
REQ-023 SHALL, in VCOL, drive address TM-A 0x000+col when i_H4=0 and TM-B 0x080+col when i_H4=1, where col = (HCNT[8:3]+1) mod 64 to prefetch the next column.
REQ-024 SHALL wrap col 63 to 0 with no carry into bit 6.
REQ-025 SHALL, in VCOL, capture VSCROLL into a staging register of the selected layer.
REQ-026 SHALL copy staging to o_TMx_VSCROLL when i_HCNT[2:0] rolls 7→0.
REQ-027 SHALL, on i_VCLK 0→1, go to IDLE; any in-flight capture SHALL be discarded.
REQ-028 SHALL, in IDLE and HDONE, hold o_GFXADDR at its last value.
REQ-029 SHALL treat a simultaneous VCLK edge and slot boundary with the VCLK edge taking priority.
REQ-030 SHALL clear o_FETCH_ERR only on reset.

Reset
REQ-031 SHALL, while i_EMU_RST_n=0, asynchronously set FSM=IDLE, o_GFXADDR=0, all scroll outputs, shadows and staging=0, and o_FETCH_ERR=0.
REQ-032 SHALL, after deassertion, wait for the first i_VCLK 1 level before starting HSCROLL fetch; a mid-line release SHALL NOT fetch until the next blank.

Structure
REQ-033 SHALL place FSM state encoding, base addresses (0x400, 0x600, 0x000, 0x080) and launch/capture phase constants in shared package scroll_pkg.
REQ-034 SHALL use one sub-module, scroll_slot_timer, to decode i_EMU_TIMING into launch, capture and addr_update strobes.

Verification
REQ-035 SHALL cover: VCNT=0x23, RAM[0x446]=0x34, RAM[0x447]=0x01, RAM[0x646]=0xFF, RAM[0x647]=0xFE, VCLK high 6 slots then low -> TMA_H=0x134, TMB_H=0x0FF one clock after the fall.
REQ-036 SHALL cover: VCLK high only 3 slots -> o_FETCH_ERR=1, HSCROLL outputs unchanged, FSM in VCOL.
REQ-037 SHALL cover: VCOL with HCNT=0x1F8 (col 63), H4=0, RAM[0x000]=0x5A -> o_GFXADDR=0x000, o_TMA_VSCROLL=0x5A at HCNT 0x000.
REQ-038 SHALL cover: H4=1, col 5, RAM[0x086]=0x77 -> o_GFXADDR=0x086, o_TMB_VSCROLL=0x77, TM-A value unchanged.
REQ-039 SHALL cover: reset asserted during HB_LO -> all outputs 0 immediately; after release mid-active-line, no GFX address change until next VCLK=1.
REQ-040 SHALL cover: o_GFXADDR sampled at every pixel 0 phase 5 and pixel 1 phase 3 -> identical values within a slot for all slots.
